frame_buffer_responder: RTL and testbench
=========================================

// Module: frame_buffer_responder
// PURPOSE
//  Responder side of the rq/ack buffer handshake used by the preprocessing stages. Owns two single-port
//  frame buffers: GRAY (camera capture writes, sobel stage reads) and RESULT (sobel stage writes,
//  display reads). Grants exclusive access per buffer, enforces produce-before-consume ordering via a
//  full flag, and muxes the granted client's address/data onto the memory port.
// PARAMETERS
//  DEPTH     76800                  pixels per frame (320x240)
//  ADDR_W    $clog2(DEPTH)          address width
//  PX_W      15                     pixel width
//  TIMEOUT   1048576                max cycles a grant may be held; 0 disables the watchdog
// PORTS
//  sobel_clk      in   1       clock, all logic on posedge
//  reset          in   1       synchronous, active-high
//  cap_rq/cap_ack              in/out 1    capture writer handshake (GRAY)
//  cap_addr, cap_px, cap_we    in ADDR_W/PX_W/1  capture write port
//  sob_rd_rq/sob_rd_ack        in/out 1    sobel reader handshake (GRAY)
//  sob_rd_addr in ADDR_W; sob_rd_px out PX_W      sobel read port
//  sob_wr_rq/sob_wr_ack        in/out 1    sobel writer handshake (RESULT)
//  sob_wr_addr, sob_wr_px, sob_wr_en in ADDR_W/PX_W/1  sobel write port
//  disp_rq/disp_ack            in/out 1    display reader handshake (RESULT)
//  disp_addr in ADDR_W; disp_px out PX_W           display read port
//  gray_addr, gray_wdata, gray_we out ADDR_W/PX_W/1; gray_rdata in PX_W    GRAY memory port
//  res_addr, res_wdata, res_we    out ADDR_W/PX_W/1; res_rdata  in PX_W    RESULT memory port
//  gray_full, res_full  out 1   frame-valid flags;  timeout_err out 1  sticky watchdog error
// BEHAVIOUR
//  - Reset: all acks 0, both FSMs IDLE, gray_full=res_full=0, timeout_err=0, hold counters 0,
//    mem addr/wdata 0, we 0. Reset mid-grant drops ack on the next edge; full flag NOT updated by it.
//  - Per-buffer FSM: IDLE, GRANT_WR, GRANT_RD, RELEASE.
//    IDLE: wr_rq && !full -> GRANT_WR; else rd_rq && full -> GRANT_RD; else stay. Only one side is
//    ever eligible, so simultaneous rq resolves by full flag; ineligible rq waits without ack.
//    GRANT_x: ack=1 (registered; visible one cycle after rq sampled in IDLE). Stay while rq high.
//    rq low -> RELEASE; on that edge GRANT_WR sets full=1, GRANT_RD clears full=0.
//    RELEASE: ack=0 for exactly one cycle, -> IDLE (new grant earliest 2 cycles after rq drop).
//  - Four-phase rule: ack never rises while rq low; ack falls only after rq falls or on timeout.
//  - Watchdog: hold counter clears on entry to GRANT_x, +1 per cycle in GRANT_x; at TIMEOUT-1 force
//    RELEASE, full unchanged, timeout_err<=1 (sticky until reset). Client must drop rq to re-request.
//  - Muxing (combinational from FSM state): mem_addr = granted client addr, else 0;
//    mem_we = writer_we && GRANT_WR; mem_wdata = writer px; reader px = mem_rdata when GRANT_RD,
//    else 0. Memory read latency (1 cycle, sync RAM) is the client's concern, not re-timed here.
//  - No address range check; addresses >= DEPTH pass through unchanged.
// STRUCTURE
//  - Shared package: FSM state encoding (2-bit IDLE=0, GRANT_WR=1, GRANT_RD=2, RELEASE=3),
//    default DEPTH/PX_W constants.
//  - Sub-module buffer_grant_fsm (FSM + full flag + watchdog + mux), instantiated twice (GRAY,
//    RESULT); top level is wiring plus OR of the two error bits into timeout_err.
// TESTING
//  1 Post-reset: sob_rd_rq=1 for 20 cycles -> sob_rd_ack stays 0, gray_full=0.
//  2 cap_rq=1 -> cap_ack=1 next cycle; write px 0x1234 @ addr 5 with cap_we -> gray_we=1,
//    gray_addr=5; drop cap_rq -> ack 0 next edge, gray_full=1; pending sob_rd_rq acked 2 cycles later.
//  3 sob_rd granted, sob_rd_addr=5 -> gray_addr=5, sob_rd_px=gray_rdata; drop rq -> gray_full=0.
//  4 cap_rq and sob_rd_rq rise same cycle with gray_full=1 -> only sob_rd_ack; cap waits till release.
//  5 TIMEOUT=16, hold sob_wr_rq -> ack drops after 16 cycles, timeout_err=1, res_full stays 0.
//  6 reset asserted during GRANT_WR on RESULT -> ack 0, res_full 0, res_we 0 on next edge.

Source files
------------

// File: rtl/frame_buffer_responder_pkg.sv
// Shared definitions for the frame buffer responder: per-buffer grant state
// encoding, default frame geometry and the watchdog counter sizing helper.
package frame_buffer_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2,
    RELEASE  = 2'd3
  } buf_state_e;

  localparam int unsigned DEFAULT_DEPTH   = 76800;
  localparam int unsigned DEFAULT_PX_W    = 15;
  localparam int unsigned DEFAULT_TIMEOUT = 1048576;

  // The hold counter only ever reaches TIMEOUT-1, so $clog2(TIMEOUT) bits
  // suffice; keep at least one bit so a disabled watchdog still elaborates.
  function automatic int unsigned hold_cnt_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer_responder_buffer_grant_fsm.sv
// One buffer's arbiter: grants a single writer or reader at a time, tracks
// whether the buffer holds a complete frame, watches how long a grant is held
// and steers the granted client onto the single memory port.
module buffer_grant_fsm
  import frame_buffer_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned PX_W    = DEFAULT_PX_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_rq,
  output logic              wr_ack,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PX_W-1:0]   wr_px,
  input  logic              wr_we,
  input  logic              rd_rq,
  output logic              rd_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PX_W-1:0]   rd_px,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PX_W-1:0]   mem_wdata,
  output logic              mem_we,
  input  logic [PX_W-1:0]   mem_rdata,
  output logic              full,
  output logic              timeout_err
);

  localparam int unsigned    CNT_W    = hold_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit             WDOG_EN  = (TIMEOUT != 0);

  buf_state_e       state_q, state_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // A client whose grant was revoked by the watchdog stays locked out until
  // it lowers its request, so a stuck client cannot immediately re-grab.
  logic             lock_wr_q, lock_wr_d;
  logic             lock_rd_q, lock_rd_d;

  // Next-state logic: eligibility is decided by the full flag, so a writer
  // and a reader can never both be eligible in the same cycle.
  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    lock_wr_d = lock_wr_q & wr_rq;
    lock_rd_d = lock_rd_q & rd_rq;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_rq && !full_q && !lock_wr_q) begin
          state_d = GRANT_WR;
        end else if (rd_rq && full_q && !lock_rd_q) begin
          state_d = GRANT_RD;
        end
      end
      GRANT_WR: begin
        if (!wr_rq) begin
          state_d = RELEASE;
          full_d  = 1'b1;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          state_d   = RELEASE;
          err_d     = 1'b1;
          lock_wr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GRANT_RD: begin
        if (!rd_rq) begin
          state_d = RELEASE;
          full_d  = 1'b0;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          state_d   = RELEASE;
          err_d     = 1'b1;
          lock_rd_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, frame-valid flag, sticky error and hold counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      lock_wr_q <= 1'b0;
      lock_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      lock_wr_q <= lock_wr_d;
      lock_rd_q <= lock_rd_d;
    end
  end

  // Acks decode straight from the registered state; the memory port follows
  // whichever client currently holds the grant and is quiet otherwise.
  always_comb begin
    wr_ack    = (state_q == GRANT_WR);
    rd_ack    = (state_q == GRANT_RD);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    rd_px     = '0;
    case (state_q)
      GRANT_WR: begin
        mem_addr  = wr_addr;
        mem_wdata = wr_px;
        mem_we    = wr_we;
      end
      GRANT_RD: begin
        mem_addr = rd_addr;
        rd_px    = mem_rdata;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign full        = full_q;
  assign timeout_err = err_q;

endmodule

// File: rtl/frame_buffer_responder.sv
// Responder for the preprocessing buffer handshake: GRAY is filled by the
// camera capture and drained by sobel, RESULT is filled by sobel and drained
// by the display. Each buffer has its own grant FSM.
module frame_buffer_responder
  import frame_buffer_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned PX_W    = DEFAULT_PX_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              sobel_clk,
  input  logic              reset,
  input  logic              cap_rq,
  output logic              cap_ack,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [PX_W-1:0]   cap_px,
  input  logic              cap_we,
  input  logic              sob_rd_rq,
  output logic              sob_rd_ack,
  input  logic [ADDR_W-1:0] sob_rd_addr,
  output logic [PX_W-1:0]   sob_rd_px,
  input  logic              sob_wr_rq,
  output logic              sob_wr_ack,
  input  logic [ADDR_W-1:0] sob_wr_addr,
  input  logic [PX_W-1:0]   sob_wr_px,
  input  logic              sob_wr_en,
  input  logic              disp_rq,
  output logic              disp_ack,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [PX_W-1:0]   disp_px,
  output logic [ADDR_W-1:0] gray_addr,
  output logic [PX_W-1:0]   gray_wdata,
  output logic              gray_we,
  input  logic [PX_W-1:0]   gray_rdata,
  output logic [ADDR_W-1:0] res_addr,
  output logic [PX_W-1:0]   res_wdata,
  output logic              res_we,
  input  logic [PX_W-1:0]   res_rdata,
  output logic              gray_full,
  output logic              res_full,
  output logic              timeout_err
);

  logic gray_err;
  logic res_err;

  buffer_grant_fsm #(
    .ADDR_W  (ADDR_W),
    .PX_W    (PX_W),
    .TIMEOUT (TIMEOUT)
  ) u_gray (
    .clk         (sobel_clk),
    .reset       (reset),
    .wr_rq       (cap_rq),
    .wr_ack      (cap_ack),
    .wr_addr     (cap_addr),
    .wr_px       (cap_px),
    .wr_we       (cap_we),
    .rd_rq       (sob_rd_rq),
    .rd_ack      (sob_rd_ack),
    .rd_addr     (sob_rd_addr),
    .rd_px       (sob_rd_px),
    .mem_addr    (gray_addr),
    .mem_wdata   (gray_wdata),
    .mem_we      (gray_we),
    .mem_rdata   (gray_rdata),
    .full        (gray_full),
    .timeout_err (gray_err)
  );

  buffer_grant_fsm #(
    .ADDR_W  (ADDR_W),
    .PX_W    (PX_W),
    .TIMEOUT (TIMEOUT)
  ) u_result (
    .clk         (sobel_clk),
    .reset       (reset),
    .wr_rq       (sob_wr_rq),
    .wr_ack      (sob_wr_ack),
    .wr_addr     (sob_wr_addr),
    .wr_px       (sob_wr_px),
    .wr_we       (sob_wr_en),
    .rd_rq       (disp_rq),
    .rd_ack      (disp_ack),
    .rd_addr     (disp_addr),
    .rd_px       (disp_px),
    .mem_addr    (res_addr),
    .mem_wdata   (res_wdata),
    .mem_we      (res_we),
    .mem_rdata   (res_rdata),
    .full        (res_full),
    .timeout_err (res_err)
  );

  assign timeout_err = gray_err | res_err;

endmodule

// File: tb/tb_frame_buffer_responder.sv
// Directed bench for the frame buffer responder: a vector table walks the
// GRAY buffer through write, read, contention and address-boundary cases,
// then hand sequences cover RESULT, the watchdog and reset mid-grant.
module tb_frame_buffer_responder;

  localparam int unsigned AW = 17;
  localparam int unsigned PW = 15;

  logic          sobel_clk = 1'b0;
  logic          reset;
  logic          cap_rq, cap_ack, cap_we;
  logic [AW-1:0] cap_addr;
  logic [PW-1:0] cap_px;
  logic          sob_rd_rq, sob_rd_ack;
  logic [AW-1:0] sob_rd_addr;
  logic [PW-1:0] sob_rd_px;
  logic          sob_wr_rq, sob_wr_ack, sob_wr_en;
  logic [AW-1:0] sob_wr_addr;
  logic [PW-1:0] sob_wr_px;
  logic          disp_rq, disp_ack;
  logic [AW-1:0] disp_addr;
  logic [PW-1:0] disp_px;
  logic [AW-1:0] gray_addr, res_addr;
  logic [PW-1:0] gray_wdata, gray_rdata, res_wdata, res_rdata;
  logic          gray_we, res_we, gray_full, res_full, timeout_err;

  int vectorCount = 0;
  int missCount   = 0;

  frame_buffer_responder #(
    .DEPTH   (76800),
    .PX_W    (PW),
    .TIMEOUT (16)
  ) dut (
    .sobel_clk   (sobel_clk),
    .reset       (reset),
    .cap_rq      (cap_rq),
    .cap_ack     (cap_ack),
    .cap_addr    (cap_addr),
    .cap_px      (cap_px),
    .cap_we      (cap_we),
    .sob_rd_rq   (sob_rd_rq),
    .sob_rd_ack  (sob_rd_ack),
    .sob_rd_addr (sob_rd_addr),
    .sob_rd_px   (sob_rd_px),
    .sob_wr_rq   (sob_wr_rq),
    .sob_wr_ack  (sob_wr_ack),
    .sob_wr_addr (sob_wr_addr),
    .sob_wr_px   (sob_wr_px),
    .sob_wr_en   (sob_wr_en),
    .disp_rq     (disp_rq),
    .disp_ack    (disp_ack),
    .disp_addr   (disp_addr),
    .disp_px     (disp_px),
    .gray_addr   (gray_addr),
    .gray_wdata  (gray_wdata),
    .gray_we     (gray_we),
    .gray_rdata  (gray_rdata),
    .res_addr    (res_addr),
    .res_wdata   (res_wdata),
    .res_we      (res_we),
    .res_rdata   (res_rdata),
    .gray_full   (gray_full),
    .res_full    (res_full),
    .timeout_err (timeout_err)
  );

  always #5 sobel_clk = ~sobel_clk;

  typedef struct {
    logic          cap_rq;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [PW-1:0] cap_px;
    logic          rd_rq;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rdata;
    logic          exp_cap_ack;
    logic          exp_rd_ack;
    logic          exp_full;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [PW-1:0] exp_wdata;
    logic [PW-1:0] exp_rd_px;
  } gray_vec_t;

  gray_vec_t vecs[20];

  function automatic gray_vec_t mkVec(
    input logic c_rq, input logic c_we, input logic [AW-1:0] c_addr, input logic [PW-1:0] c_px,
    input logic r_rq, input logic [AW-1:0] r_addr, input logic [PW-1:0] rd,
    input logic e_cack, input logic e_rack, input logic e_full, input logic [AW-1:0] e_addr,
    input logic e_we, input logic [PW-1:0] e_wdata, input logic [PW-1:0] e_rpx);
    gray_vec_t v;
    v.cap_rq = c_rq;   v.cap_we = c_we;  v.cap_addr = c_addr; v.cap_px = c_px;
    v.rd_rq = r_rq;    v.rd_addr = r_addr; v.rdata = rd;
    v.exp_cap_ack = e_cack; v.exp_rd_ack = e_rack; v.exp_full = e_full;
    v.exp_addr = e_addr; v.exp_we = e_we; v.exp_wdata = e_wdata; v.exp_rd_px = e_rpx;
    return v;
  endfunction

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge sobel_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input gray_vec_t v);
    cap_rq      = v.cap_rq;
    cap_we      = v.cap_we;
    cap_addr    = v.cap_addr;
    cap_px      = v.cap_px;
    sob_rd_rq   = v.rd_rq;
    sob_rd_addr = v.rd_addr;
    gray_rdata  = v.rdata;
  endtask

  initial begin
    reset = 1'b1;
    cap_rq = 0; cap_we = 0; cap_addr = '0; cap_px = '0;
    sob_rd_rq = 0; sob_rd_addr = '0; gray_rdata = '0;
    sob_wr_rq = 0; sob_wr_en = 0; sob_wr_addr = '0; sob_wr_px = '0;
    disp_rq = 0; disp_addr = '0; res_rdata = '0;

    // Reset state
    tick(); tick();
    checkOutput("rst.cap_ack", 32'(cap_ack), 0);
    checkOutput("rst.sob_wr_ack", 32'(sob_wr_ack), 0);
    checkOutput("rst.gray_full", 32'(gray_full), 0);
    checkOutput("rst.res_full", 32'(res_full), 0);
    checkOutput("rst.timeout_err", 32'(timeout_err), 0);
    checkOutput("rst.gray_addr", 32'(gray_addr), 0);
    checkOutput("rst.res_we", 32'(res_we), 0);
    reset = 1'b0;

    // Reader asking for an empty buffer is never acknowledged
    sob_rd_rq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput($sformatf("empty_rd.ack[%0d]", i), 32'(sob_rd_ack), 0);
    end
    checkOutput("empty_rd.gray_full", 32'(gray_full), 0);

    // GRAY buffer vector table
    vecs[0]  = mkVec(0,0,17'd0,15'h0,      0,17'd0,15'h0,      0,0,0,17'd0,0,15'h0,15'h0);
    vecs[1]  = mkVec(0,0,17'd0,15'h0,      1,17'd9,15'h0AAA,   0,0,0,17'd0,0,15'h0,15'h0);
    vecs[2]  = mkVec(0,0,17'd0,15'h0,      1,17'd9,15'h0AAA,   0,0,0,17'd0,0,15'h0,15'h0);
    vecs[3]  = mkVec(1,1,17'd5,15'h1234,   1,17'd9,15'h0AAA,   1,0,0,17'd5,1,15'h1234,15'h0);
    vecs[4]  = mkVec(1,0,17'd6,15'h7FFF,   1,17'd9,15'h0AAA,   1,0,0,17'd6,0,15'h7FFF,15'h0);
    vecs[5]  = mkVec(0,0,17'd6,15'h7FFF,   1,17'd9,15'h0AAA,   0,0,1,17'd0,0,15'h0,15'h0);
    vecs[6]  = mkVec(0,0,17'd6,15'h7FFF,   1,17'd9,15'h0AAA,   0,0,1,17'd0,0,15'h0,15'h0);
    vecs[7]  = mkVec(0,0,17'd6,15'h7FFF,   1,17'd9,15'h0AAA,   0,1,1,17'd9,0,15'h0,15'h0AAA);
    vecs[8]  = mkVec(1,1,17'd6,15'h7FFF,   1,17'd5,15'h1234,   0,1,1,17'd5,0,15'h0,15'h1234);
    vecs[9]  = mkVec(1,1,17'd6,15'h7FFF,   0,17'd5,15'h1234,   0,0,0,17'd0,0,15'h0,15'h0);
    vecs[10] = mkVec(1,1,17'd6,15'h7FFF,   0,17'd5,15'h1234,   0,0,0,17'd0,0,15'h0,15'h0);
    vecs[11] = mkVec(1,1,17'h12C00,15'h55, 0,17'd0,15'h0,      1,0,0,17'h12C00,1,15'h55,15'h0);
    vecs[12] = mkVec(1,1,17'h1FFFF,15'h55, 0,17'd0,15'h0,      1,0,0,17'h1FFFF,1,15'h55,15'h0);
    vecs[13] = mkVec(0,0,17'd0,15'h0,      0,17'd0,15'h0,      0,0,1,17'd0,0,15'h0,15'h0);
    vecs[14] = mkVec(0,0,17'd0,15'h0,      0,17'd0,15'h0,      0,0,1,17'd0,0,15'h0,15'h0);
    vecs[15] = mkVec(1,1,17'd3,15'h0777,   1,17'd3,15'h0101,   0,1,1,17'd3,0,15'h0,15'h0101);
    vecs[16] = mkVec(1,1,17'd3,15'h0777,   0,17'd3,15'h0101,   0,0,0,17'd0,0,15'h0,15'h0);
    vecs[17] = mkVec(1,1,17'd3,15'h0777,   0,17'd3,15'h0101,   0,0,0,17'd0,0,15'h0,15'h0);
    vecs[18] = mkVec(1,1,17'd7,15'h2222,   0,17'd0,15'h0,      1,0,0,17'd7,1,15'h2222,15'h0);
    vecs[19] = mkVec(0,0,17'd7,15'h2222,   0,17'd0,15'h0,      0,0,1,17'd0,0,15'h0,15'h0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d.cap_ack", i), 32'(cap_ack), 32'(vecs[i].exp_cap_ack));
      checkOutput($sformatf("v%0d.sob_rd_ack", i), 32'(sob_rd_ack), 32'(vecs[i].exp_rd_ack));
      checkOutput($sformatf("v%0d.gray_full", i), 32'(gray_full), 32'(vecs[i].exp_full));
      checkOutput($sformatf("v%0d.gray_addr", i), 32'(gray_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("v%0d.gray_we", i), 32'(gray_we), 32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d.gray_wdata", i), 32'(gray_wdata), 32'(vecs[i].exp_wdata));
      checkOutput($sformatf("v%0d.sob_rd_px", i), 32'(sob_rd_px), 32'(vecs[i].exp_rd_px));
    end
    cap_rq = 0; cap_we = 0; sob_rd_rq = 0;

    // RESULT buffer: sobel write then display read
    sob_wr_rq = 1; sob_wr_en = 1; sob_wr_addr = 17'd10; sob_wr_px = 15'h0ABC;
    tick();
    checkOutput("res_wr.ack", 32'(sob_wr_ack), 1);
    checkOutput("res_wr.we", 32'(res_we), 1);
    checkOutput("res_wr.addr", 32'(res_addr), 10);
    checkOutput("res_wr.wdata", 32'(res_wdata), 32'h0ABC);
    sob_wr_rq = 0; sob_wr_en = 0;
    tick();
    checkOutput("res_wr_rel.ack", 32'(sob_wr_ack), 0);
    checkOutput("res_wr_rel.full", 32'(res_full), 1);
    tick();
    disp_rq = 1; disp_addr = 17'd10; res_rdata = 15'h0ABC;
    tick();
    checkOutput("disp.ack", 32'(disp_ack), 1);
    checkOutput("disp.addr", 32'(res_addr), 10);
    checkOutput("disp.px", 32'(disp_px), 32'h0ABC);
    disp_rq = 0;
    tick();
    checkOutput("disp_rel.full", 32'(res_full), 0);
    tick();

    // Watchdog: held grant is revoked after 16 cycles
    sob_wr_rq = 1;
    begin
      int held = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (sob_wr_ack) held++;
        else if (held > 0) break;
      end
      checkOutput("wdog.held_cycles", 32'(held), 16);
    end
    checkOutput("wdog.timeout_err", 32'(timeout_err), 1);
    checkOutput("wdog.res_full", 32'(res_full), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("wdog_lock.ack[%0d]", i), 32'(sob_wr_ack), 0);
    end
    sob_wr_rq = 0;
    tick();
    checkOutput("wdog_sticky.err", 32'(timeout_err), 1);

    // Re-request after dropping, then reset in the middle of the grant
    sob_wr_rq = 1; sob_wr_en = 1; sob_wr_addr = 17'd3;
    tick();
    checkOutput("regrant.ack", 32'(sob_wr_ack), 1);
    checkOutput("regrant.we", 32'(res_we), 1);
    reset = 1;
    tick();
    checkOutput("rst_grant.ack", 32'(sob_wr_ack), 0);
    checkOutput("rst_grant.full", 32'(res_full), 0);
    checkOutput("rst_grant.we", 32'(res_we), 0);
    checkOutput("rst_grant.err", 32'(timeout_err), 0);
    reset = 0; sob_wr_rq = 0; sob_wr_en = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
